// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   DEF_WIDTH / DEF_CNT_W : default operand and chain-count widths
//   OP_*                  : 2-bit ALU opcode encodings
//   state_t               : sequencer FSM states
package alu_op_sequencer_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 4;
    localparam int unsigned OP_W      = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_iter_counter.sv
// Chain iteration bookkeeping for the ALU sequencer.
//   clk, reset : clock and synchronous active-high reset
//   load, cnt  : start a command with cnt extra iterations
//   step       : one chained iteration has been issued
//   ops        : operations issued so far for the current command (registered)
//   done_c     : no iterations remain (combinational from the remaining count)
module alu_op_sequencer_iter_counter
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W:0]   ops,
    output logic             done_c
);

    localparam int unsigned OPS_W = CNT_W + 1;

    logic [CNT_W-1:0] remaining;

    // Load on accept, count down the remaining chain while counting ops up.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            ops       <= '0;
        end else if (load) begin
            remaining <= cnt;
            ops       <= OPS_W'(1);
        end else if (step) begin
            remaining <= remaining - CNT_W'(1);
            ops       <= ops + OPS_W'(1);
        end
    end

    assign done_c = (remaining == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for an external combinational 4-bit ALU: accepts a command,
// drives registered operands/opcode, optionally chains the result back into
// operand A, and returns the final result over a valid/ready response port.
//   clk, reset                       : clock, synchronous active-high reset
//   cmd_valid/ready, cmd_a/b/op/cnt  : command handshake and payload
//   alu_a/b/op (out), alu_ans (in)   : connection to the external ALU
//   rsp_valid/ready, rsp_data/ops    : response handshake and payload
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_ans,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [CNT_W:0]   rsp_ops
);

    state_t         state;
    logic           load_c;
    logic           step_c;
    logic           done_c;
    logic [CNT_W:0] ops;

    assign load_c = (state == S_IDLE) && cmd_valid;
    assign step_c = (state == S_EXEC) && !done_c;

    alu_op_sequencer_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .step   (step_c),
        .cnt    (cmd_cnt),
        .ops    (ops),
        .done_c (done_c)
    );

    // Sequencer FSM; the ALU result is only ever sampled, never recomputed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ops   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_op    <= cmd_op;
                        cmd_ready <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (done_c) begin
                        rsp_data  <= alu_ans;
                        rsp_ops   <= ops;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        // Chain: the result becomes the next operand A.
                        alu_a <= alu_ans;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_ans;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [4:0] rsp_ops;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Reference ALU behaviour: 00 AND, 01 OR, 10 XOR, 11 ADD modulo 16.
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return 4'((32'(a) + 32'(b)) % 16);
        endcase
    endfunction

    assign alu_ans = alu_f(alu_a, alu_b, alu_op);

    alu_op_sequencer #(
        .WIDTH (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_ans   (alu_ans),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ops   (rsp_ops)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a command while in IDLE and let it be accepted on the next edge.
    task automatic accept_cmd(input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] op, input logic [3:0] cnt);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_valid = 1'b1;
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        cmd_cnt   = 4'($urandom);
    endtask

    // Follow the chain from just after acceptance until the response appears.
    task automatic exec_and_check(input logic [3:0] a, input logic [3:0] b,
                                  input logic [1:0] op, input logic [3:0] cnt);
        logic [3:0] x;
        x = a;
        for (int k = 0; k <= 32'(cnt); k++) begin
            check("exec_alu_a", 32'(alu_a), 32'(x));
            check("exec_alu_b", 32'(alu_b), 32'(b));
            check("exec_alu_op", 32'(alu_op), 32'(op));
            check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
            check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            x = alu_f(x, b, op);
            tick();
        end
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(x));
        check("rsp_ops", 32'(rsp_ops), 32'(cnt) + 32'd1);
    endtask

    // Hold the response off for hold cycles, then complete the handshake.
    task automatic finish_rsp(input int hold, input logic [3:0] exp_data,
                              input logic [3:0] held_a);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_alu_a", 32'(alu_a), 32'(held_a));
        end
        rsp_ready = 1'b1;
        tick();
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    function automatic logic [3:0] chain_last_a(input logic [3:0] a, input logic [3:0] b,
                                                input logic [1:0] op, input logic [3:0] cnt);
        logic [3:0] x;
        x = a;
        for (int k = 0; k < 32'(cnt); k++) x = alu_f(x, b, op);
        return x;
    endfunction

    initial begin
        logic       seen;
        logic [3:0] ra, rb, rc;
        logic [1:0] rop;
        int         hold;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_cnt   = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_ops", 32'(rsp_ops), 32'd0);

        // 1: ADD 3+4, single op; rsp_ready high before valid has no effect
        rsp_ready = 1'b1;
        tick();
        check("idle_no_rsp", 32'(rsp_valid), 32'd0);
        accept_cmd(4'd3, 4'd4, 2'b11, 4'd0);
        exec_and_check(4'd3, 4'd4, 2'b11, 4'd0);
        check("t1_data", 32'(rsp_data), 32'd7);
        finish_rsp(0, 4'd7, 4'd3);

        // 2: chained ADD 1+1 x4
        accept_cmd(4'd1, 4'd1, 2'b11, 4'd3);
        exec_and_check(4'd1, 4'd1, 2'b11, 4'd3);
        check("t2_data", 32'(rsp_data), 32'd5);
        finish_rsp(0, 4'd5, 4'd4);

        // 3: ADD wrap, then XOR chain
        accept_cmd(4'd15, 4'd1, 2'b11, 4'd0);
        exec_and_check(4'd15, 4'd1, 2'b11, 4'd0);
        check("t3_wrap", 32'(rsp_data), 32'd0);
        finish_rsp(0, 4'd0, 4'd15);
        accept_cmd(4'd5, 4'd3, 2'b10, 4'd1);
        exec_and_check(4'd5, 4'd3, 2'b10, 4'd1);
        check("t3_xor", 32'(rsp_data), 32'd5);
        finish_rsp(0, 4'd5, 4'd6);

        // 4: AND with backpressure and a stray command while busy
        accept_cmd(4'd12, 4'd10, 2'b00, 4'd0);
        exec_and_check(4'd12, 4'd10, 2'b00, 4'd0);
        check("t4_data", 32'(rsp_data), 32'd8);
        cmd_a     = 4'd9;
        cmd_b     = 4'd2;
        cmd_op    = 2'b01;
        cmd_cnt   = 4'd0;
        cmd_valid = 1'b1;
        finish_rsp(5, 4'd8, 4'd12);
        check("t4_stray_not_latched", 32'(alu_a), 32'd12);
        tick();
        cmd_valid = 1'b0;
        exec_and_check(4'd9, 4'd2, 2'b01, 4'd0);
        check("t4_stray_result", 32'(rsp_data), 32'd11);
        finish_rsp(0, 4'd11, 4'd9);

        // 5: reset in the middle of a long chain
        accept_cmd(4'd0, 4'd1, 2'b11, 4'd15);
        tick();
        tick();
        tick();
        check("t5_mid_exec_a", 32'(alu_a), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_alu_a", 32'(alu_a), 32'd0);
        check("t5_alu_b", 32'(alu_b), 32'd0);
        check("t5_alu_op", 32'(alu_op), 32'd0);
        check("t5_rsp_ops", 32'(rsp_ops), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        check("t5_no_response", 32'(seen), 32'd0);

        // 5b: full-length chain, 16 ops, ops count must not wrap
        accept_cmd(4'd0, 4'd1, 2'b11, 4'd15);
        exec_and_check(4'd0, 4'd1, 2'b11, 4'd15);
        check("t5b_ops16", 32'(rsp_ops), 32'd16);
        finish_rsp(0, 4'd0, 4'd15);

        // 6: back-to-back, exactly one IDLE bubble
        accept_cmd(4'd9, 4'd6, 2'b01, 4'd0);
        exec_and_check(4'd9, 4'd6, 2'b01, 4'd0);
        check("t6_or", 32'(rsp_data), 32'd15);
        finish_rsp(0, 4'd15, 4'd9);
        accept_cmd(4'd15, 4'd3, 2'b00, 4'd0);
        exec_and_check(4'd15, 4'd3, 2'b00, 4'd0);
        check("t6_and", 32'(rsp_data), 32'd3);
        finish_rsp(0, 4'd3, 4'd15);

        // Randomized commands against the reference model
        for (int n = 0; n < 25; n++) begin
            ra   = 4'($urandom);
            rb   = 4'($urandom);
            rop  = 2'($urandom);
            rc   = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tick();
            accept_cmd(ra, rb, rop, rc);
            exec_and_check(ra, rb, rop, rc);
            finish_rsp(hold, alu_f(chain_last_a(ra, rb, rop, rc), rb, rop),
                       chain_last_a(ra, rb, rop, rc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
